// File: rtl/reg_wb_arbiter.sv
// Register write-back arbiter: fixed-latency ALU path with strict priority
// over a small in-order load queue whose stale entries are squashed.
module reg_wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         alu_valid,
    input  logic [2:0]   alu_reg,
    input  logic [W-1:0] alu_data,
    input  logic         ld_valid,
    output logic         ld_ready,
    input  logic [2:0]   ld_reg,
    input  logic [W-1:0] ld_data,
    output logic         RegWrite,
    output logic [2:0]   WriteReg,
    output logic [W-1:0] WriteData,
    output logic [7:0]   pend_mask
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [2:0]       q_reg  [DEPTH];
    logic [W-1:0]     q_data [DEPTH];
    logic [DEPTH-1:0] q_live;
    logic [DEPTH-1:0] live_nxt;
    logic [7:0]       pend_nxt;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;
    logic             head_live;
    logic [2:0]       reg_sel;

    assign ld_ready  = (count < FULL) && !rst;
    assign push      = ld_valid && ld_ready;
    assign pop       = !rst && !alu_valid && (count != '0);
    assign head_live = q_live[rd_ptr];

    // Squash before push: a load pushed alongside a matching ALU write is younger.
    always_comb begin
        live_nxt = q_live;
        pend_nxt = '0;
        reg_sel  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_valid && !rst && q_reg[i] == alu_reg)
                live_nxt[i] = 1'b0;
            if (pop && AW'(i) == rd_ptr)
                live_nxt[i] = 1'b0;
            if (push && AW'(i) == wr_ptr)
                live_nxt[i] = 1'b1;
        end
        for (int i = 0; i < DEPTH; i++) begin
            reg_sel = (push && AW'(i) == wr_ptr) ? ld_reg : q_reg[i];
            if (live_nxt[i])
                pend_nxt[reg_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_reg[wr_ptr]  <= ld_reg;
            q_data[wr_ptr] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_live    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pend_mask <= '0;
        end else begin
            q_live    <= live_nxt;
            pend_mask <= pend_nxt;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A dead head still burns its pop slot but writes nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else if (alu_valid) begin
            RegWrite  <= 1'b1;
            WriteReg  <= alu_reg;
            WriteData <= alu_data;
        end else if (pop && head_live) begin
            RegWrite  <= 1'b1;
            WriteReg  <= q_reg[rd_ptr];
            WriteData <= q_data[rd_ptr];
        end else begin
            RegWrite  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: vector table plus a reset-mid-queue
// sequence, all expectations hand-computed.
module tb_reg_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [2:0]  alu_reg = '0;
    logic [15:0] alu_data = '0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [2:0]  ld_reg = '0;
    logic [15:0] ld_data = '0;
    logic        RegWrite;
    logic [2:0]  WriteReg;
    logic [15:0] WriteData;
    logic [7:0]  pend_mask;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    reg_wb_arbiter #(.DEPTH(2), .W(16)) dut (
        .clk(clk),
        .rst(rst),
        .alu_valid(alu_valid),
        .alu_reg(alu_reg),
        .alu_data(alu_data),
        .ld_valid(ld_valid),
        .ld_ready(ld_ready),
        .ld_reg(ld_reg),
        .ld_data(ld_data),
        .RegWrite(RegWrite),
        .WriteReg(WriteReg),
        .WriteData(WriteData),
        .pend_mask(pend_mask)
    );

    typedef struct packed {
        logic        rst;
        logic        av;
        logic [2:0]  ar;
        logic [15:0] ad;
        logic        lv;
        logic [2:0]  lr;
        logic [15:0] ldd;
        logic        rw;
        logic [2:0]  wr;
        logic [15:0] wd;
        logic [7:0]  pm;
        logic        rdy;
    } vec_t;

    vec_t vt [24];

    function automatic vec_t mk(
        input logic rs, input logic av, input logic [2:0] ar,
        input logic [15:0] ad, input logic lv, input logic [2:0] lr,
        input logic [15:0] ldd, input logic rw, input logic [2:0] wr,
        input logic [15:0] wd, input logic [7:0] pm, input logic rdy);
        vec_t v;
        v.rst = rs; v.av = av; v.ar = ar; v.ad = ad;
        v.lv = lv; v.lr = lr; v.ldd = ldd;
        v.rw = rw; v.wr = wr; v.wd = wd; v.pm = pm; v.rdy = rdy;
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s step %0d: got %0h, expected %0h",
                     name, idx, act, exp);
    endtask

    task automatic drive(input logic rs, input logic av,
                         input logic [2:0] ar, input logic [15:0] ad,
                         input logic lv, input logic [2:0] lr,
                         input logic [15:0] ldd);
        @(negedge clk);
        rst = rs; alu_valid = av; alu_reg = ar; alu_data = ad;
        ld_valid = lv; ld_reg = lr; ld_data = ldd;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int idx,
                             input logic rw, input logic [2:0] wr,
                             input logic [15:0] wd, input logic [7:0] pm,
                             input logic rdy);
        check({tag, ".RegWrite"},  idx, 32'(RegWrite),  32'(rw));
        check({tag, ".WriteReg"},  idx, 32'(WriteReg),  32'(wr));
        check({tag, ".WriteData"}, idx, 32'(WriteData), 32'(wd));
        check({tag, ".pend_mask"}, idx, 32'(pend_mask), 32'(pm));
        check({tag, ".ld_ready"},  idx, 32'(ld_ready),  32'(rdy));
    endtask

    initial begin
        // reset, then ALU only
        vt[0]  = mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 8'h00, 0);
        vt[1]  = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 8'h00, 1);
        vt[2]  = mk(0, 1, 3, 16'h1234, 0, 0, 16'h0000, 1, 3, 16'h1234, 8'h00, 1);
        vt[3]  = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 3, 16'h1234, 8'h00, 1);
        // load only
        vt[4]  = mk(0, 0, 0, 16'h0000, 1, 5, 16'hBEEF, 0, 3, 16'h1234, 8'h20, 1);
        vt[5]  = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 5, 16'hBEEF, 8'h00, 1);
        vt[6]  = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 5, 16'hBEEF, 8'h00, 1);
        // full queue under held ALU, then drain in order
        vt[7]  = mk(0, 1, 7, 16'h0700, 1, 1, 16'h0011, 1, 7, 16'h0700, 8'h02, 1);
        vt[8]  = mk(0, 1, 7, 16'h0701, 1, 2, 16'h0022, 1, 7, 16'h0701, 8'h06, 0);
        vt[9]  = mk(0, 1, 7, 16'h0702, 1, 3, 16'h0033, 1, 7, 16'h0702, 8'h06, 0);
        vt[10] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h0011, 8'h04, 1);
        vt[11] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 2, 16'h0022, 8'h00, 1);
        vt[12] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 2, 16'h0022, 8'h00, 1);
        // supersede: queued load r4 killed by later ALU r4
        vt[13] = mk(0, 0, 0, 16'h0000, 1, 4, 16'h0001, 0, 2, 16'h0022, 8'h10, 1);
        vt[14] = mk(0, 1, 4, 16'h0002, 0, 0, 16'h0000, 1, 4, 16'h0002, 8'h00, 1);
        vt[15] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 4, 16'h0002, 8'h00, 1);
        vt[16] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 4, 16'h0002, 8'h00, 1);
        // same-cycle ALU and load to r6
        vt[17] = mk(0, 1, 6, 16'hAAAA, 1, 6, 16'h5555, 1, 6, 16'hAAAA, 8'h40, 1);
        vt[18] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 6, 16'h5555, 8'h00, 1);
        vt[19] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 6, 16'h5555, 8'h00, 1);
        // push and pop in the same cycle
        vt[20] = mk(0, 0, 0, 16'h0000, 1, 1, 16'h0101, 0, 6, 16'h5555, 8'h02, 1);
        vt[21] = mk(0, 0, 0, 16'h0000, 1, 2, 16'h0202, 1, 1, 16'h0101, 8'h04, 1);
        vt[22] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 2, 16'h0202, 8'h00, 1);
        vt[23] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 2, 16'h0202, 8'h00, 1);

        for (int i = 0; i < 24; i++) begin
            drive(vt[i].rst, vt[i].av, vt[i].ar, vt[i].ad,
                  vt[i].lv, vt[i].lr, vt[i].ldd);
            check_out("vec", i, vt[i].rw, vt[i].wr, vt[i].wd,
                      vt[i].pm, vt[i].rdy);
        end

        // reset mid-queue: two loads parked behind a held ALU, then rst
        drive(0, 1, 0, 16'h0C00, 1, 1, 16'h0AAA);
        check_out("rq", 0, 1, 0, 16'h0C00, 8'h02, 1);
        drive(0, 1, 0, 16'h0C01, 1, 2, 16'h0BBB);
        check_out("rq", 1, 1, 0, 16'h0C01, 8'h06, 0);
        drive(1, 1, 5, 16'h0D00, 0, 0, 16'h0000);
        check_out("rq", 2, 0, 0, 16'h0000, 8'h00, 0);
        drive(0, 0, 0, 16'h0000, 0, 0, 16'h0000);
        check_out("rq", 3, 0, 0, 16'h0000, 8'h00, 1);
        drive(0, 0, 0, 16'h0000, 0, 0, 16'h0000);
        check_out("rq", 4, 0, 0, 16'h0000, 8'h00, 1);
        // queue really empty: one push leaves room for another
        drive(0, 1, 3, 16'h0E00, 1, 7, 16'h0777);
        check_out("rq", 5, 1, 3, 16'h0E00, 8'h80, 1);
        drive(0, 0, 0, 16'h0000, 0, 0, 16'h0000);
        check_out("rq", 6, 1, 7, 16'h0777, 8'h00, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
